tbc_resp_checker: RTL
=====================

// Module: tbc_resp_checker
// PURPOSE
//  Self-checking response monitor for the 4-input/3-output tbc logic block; the
//  checking end of its exhaustive {a,b,c,d} stimulus sweep. Samples each applied
//  vector with its f1..f3 response and compares it against a parameterised truth table.
//  Tracks vector coverage and counts mismatches, logging the first failure.
//  Reports done/pass/timeout. Sits beside tbc on the lab board or in a bench harness.
// PARAMETERS
//  EXP_TABLE  48'h0    expected {f1,f2,f3} for vector i at bits [3*i+2:3*i], i={a,b,c,d}
//  TIMEOUT    16'd1000 max clk cycles in RUN before forced DONE; 0 disables timeout
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous active-high reset
//  start          in   1   1-cycle pulse: clear results and enter RUN
//  smp_valid      in   1   a,b,c,d,f1,f2,f3 are settled; sample this cycle
//  a,b,c,d        in   1   applied input vector; a is MSB of index
//  f1,f2,f3       in   1   DUT outputs for that vector; f1 is MSB of response
//  busy           out  1   FSM in RUN
//  done           out  1   FSM in DONE; held until start or rst
//  pass           out  1   valid while done: all 16 seen, err_cnt==0, no timeout
//  timeout        out  1   DONE reached by timeout (sticky until start/rst)
//  err_cnt        out  5   mismatch count, saturates at 31
//  vec_seen       out  16  bit i set once vector i sampled in RUN
//  first_err_vld  out  1   a mismatch has been logged
//  first_err_vec  out  4   index of first mismatching sample
//  first_err_got  out  3   {f1,f2,f3} observed at first mismatch
// BEHAVIOUR
//  - rst: state=IDLE; every output and internal counter cleared to 0.
//  - FSM IDLE -start-> RUN; RUN -(vec_seen all ones | timeout)-> DONE; DONE -start-> RUN.
//  - start in any state (incl. RUN): same-cycle clear of err_cnt, vec_seen, first_err_*,
//    timeout, cycle counter; next state RUN. start has priority over smp_valid.
//  - smp_valid honoured only in RUN; ignored in IDLE/DONE.
//  - Sample at edge N: idx={a,b,c,d}; exp=EXP_TABLE[3*idx+:3]; got={f1,f2,f3}.
//    At edge N+1: vec_seen[idx]=1; if got!=exp: err_cnt+=1 (sat 31) and, if
//    !first_err_vld, latch idx/got and set first_err_vld. 1-cycle result latency.
//  - Duplicate vectors: compared and counted again; vec_seen unchanged.
//  - Completion: the edge that sets the last vec_seen bit also moves to DONE;
//    done=1 from that edge; pass computed including that final sample.
//  - Timeout: 16-bit cycle counter increments each RUN cycle; reaching TIMEOUT
//    (TIMEOUT!=0) moves to DONE, sets timeout=1, pass=0. If completion and timeout
//    occur on the same edge, completion wins (timeout=0).
//  - pass=0 whenever done=0. busy=1 only in RUN. Async rst mid-RUN aborts immediately.
// TESTING (EXP_TABLE=48'hFAC688FAC688, i.e. entry i = i[2:0]; TIMEOUT=1000)
//  - Correct sweep: start, 16 samples idx 0..15 got=idx[2:0] -> done=1 edge after
//    idx 15, pass=1, err_cnt=0, vec_seen=16'hFFFF, first_err_vld=0.
//  - Fault at idx 5 got=3'b000, rest correct -> done=1, pass=0, err_cnt=1,
//    first_err_vld=1, first_err_vec=4'd5, first_err_got=3'b000.
//  - Only idx 0..14 sampled, then idle -> after 1000 RUN cycles done=1, timeout=1,
//    pass=0, vec_seen=16'h7FFF.
//  - 40 wrong samples of idx 3 then full correct sweep -> err_cnt=31 (saturated),
//    first_err_vec=4'd3, pass=0.
//  - rst pulse after 8 samples -> all outputs 0 asynchronously, state IDLE; following
//    smp_valid ignored (vec_seen stays 0) until start.
//  - start asserted with smp_valid on same cycle in DONE -> results cleared, that
//    sample not recorded; next correct sweep gives pass=1.

Source files
------------

// File: rtl/tbc_resp_checker_if.sv
// tbc_resp_checker_if: sample/response bus between the tbc stimulus side and the checker.
interface tbc_resp_checker_if;
  logic start;
  logic smp_valid;
  logic a, b, c, d;
  logic f1, f2, f3;
  logic busy;
  logic done;
  logic pass;
  logic timeout;
  logic [4:0] err_cnt;
  logic [15:0] vec_seen;
  logic first_err_vld;
  logic [3:0] first_err_vec;
  logic [2:0] first_err_got;
  modport master (
    output start, smp_valid, a, b, c, d, f1, f2, f3,
    input  busy, done, pass, timeout, err_cnt, vec_seen, first_err_vld, first_err_vec, first_err_got
  );
  modport slave (
    input  start, smp_valid, a, b, c, d, f1, f2, f3,
    output busy, done, pass, timeout, err_cnt, vec_seen, first_err_vld, first_err_vec, first_err_got
  );
endinterface

// File: rtl/tbc_resp_checker.sv
// tbc_resp_checker: compares sampled tbc responses against a truth table, tracking coverage and errors.
module tbc_resp_checker #(
  parameter logic [47:0] EXP_TABLE = 48'h0,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input logic clk,
  input logic rst,
  tbc_resp_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic p_vld;
  logic [3:0] p_idx;
  logic [2:0] p_got;
  logic [15:0] cyc, cyc_n, vec_seen, seen_n;
  logic [4:0] err_cnt;
  logic timeout, first_err_vld, mis;
  logic [3:0] first_err_vec;
  logic [2:0] first_err_got;
  logic [5:0] base;
  // samples are registered first, then scored on the following edge
  always_comb begin
    base = {2'b0, p_idx} + {1'b0, p_idx, 1'b0};
    seen_n = vec_seen | (p_vld ? 16'b1 << p_idx : 16'h0);
    mis = p_vld && (p_got != EXP_TABLE[base +: 3]);
    cyc_n = cyc + 16'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      p_vld <= 1'b0;
      p_idx <= 4'd0;
      p_got <= 3'd0;
      cyc <= 16'd0;
      vec_seen <= 16'd0;
      err_cnt <= 5'd0;
      timeout <= 1'b0;
      first_err_vld <= 1'b0;
      first_err_vec <= 4'd0;
      first_err_got <= 3'd0;
    end else if (bus.start) begin
      state <= RUN;
      p_vld <= 1'b0;
      cyc <= 16'd0;
      vec_seen <= 16'd0;
      err_cnt <= 5'd0;
      timeout <= 1'b0;
      first_err_vld <= 1'b0;
      first_err_vec <= 4'd0;
      first_err_got <= 3'd0;
    end else begin
      p_vld <= (state == RUN) && bus.smp_valid;
      p_idx <= {bus.a, bus.b, bus.c, bus.d};
      p_got <= {bus.f1, bus.f2, bus.f3};
      if (state == RUN) begin
        vec_seen <= seen_n;
        cyc <= cyc_n;
        if (mis) begin
          err_cnt <= (err_cnt == 5'd31) ? err_cnt : err_cnt + 5'd1;
          if (!first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_vec <= p_idx;
            first_err_got <= p_got;
          end
        end
        // completion outranks a coincident timeout
        if (&seen_n) state <= DONE;
        else if (TIMEOUT != 16'd0 && cyc_n == TIMEOUT) begin
          state <= DONE;
          timeout <= 1'b1;
        end
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.pass = (state == DONE) && (&vec_seen) && (err_cnt == 5'd0) && !timeout;
  assign bus.timeout = timeout;
  assign bus.err_cnt = err_cnt;
  assign bus.vec_seen = vec_seen;
  assign bus.first_err_vld = first_err_vld;
  assign bus.first_err_vec = first_err_vec;
  assign bus.first_err_got = first_err_got;
endmodule
